// File: rtl/load_store_unit_if.sv
// Request/response and data-memory bus of the load/store unit.
// The LSU uses the slave modport; the pipeline/memory side uses master.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_we;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata,
        input  resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_addr, mem_wdata, mem_we
    );

    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata,
        output resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, read-modify-write for sb/sh, RV32I load extension.
// Optional feature macro: LSU_MISALIGN_CHECK_EN (report misaligned lh/lhu/sh/lw/sw as errors).
module load_store_unit #(
    parameter int unsigned MEM_WORDS = 256
) (
    input  logic              clk,
    input  logic              rst,
    load_store_unit_if.slave  bus
);
    localparam logic [31:0] ADDR_LIMIT = 32'(MEM_WORDS) << 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t      state_r;
    logic        store_r;
    logic [2:0]  funct3_r;
    logic [1:0]  addr_lo_r;
    logic [15:0] wdata_lo_r;
    logic        req_ready_r;
    logic        resp_valid_r;
    logic        resp_err_r;
    logic [31:0] resp_rdata_r;
    logic [31:0] mem_addr_r;
    logic [31:0] mem_wdata_r;
    logic [1:0]  mem_we_r;
    logic        misalign_s;
    logic        req_err_s;

    function automatic logic funct3_illegal(input logic store, input logic [2:0] f3);
        case (f3)
            3'b000, 3'b001, 3'b010: funct3_illegal = 1'b0;
            3'b100, 3'b101:         funct3_illegal = store;
            default:                funct3_illegal = 1'b1;
        endcase
    endfunction

    // Select the lane at the latched offset and sign/zero-extend it.
    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] f3,
                                                input logic [1:0] lo);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lo, 3'b000} +: 8];
        h = lo[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  load_extend = {{24{b[7]}}, b};
            3'b001:  load_extend = {{16{h[15]}}, h};
            3'b010:  load_extend = word;
            3'b100:  load_extend = {24'd0, b};
            3'b101:  load_extend = {16'd0, h};
            default: load_extend = 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [15:0] data,
                                                input logic [2:0] f3, input logic [1:0] lo);
        logic [31:0] m;
        m = word;
        case (f3)
            3'b000: m[{lo, 3'b000} +: 8] = data[7:0];
            3'b001: begin
                if (lo[1]) begin
                    m[31:16] = data;
                end else begin
                    m[15:0] = data;
                end
            end
            default: m = word;
        endcase
        return m;
    endfunction

    // Misalignment detection of the incoming request.
    always_comb begin
        misalign_s = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
        case (bus.req_funct3)
            3'b001, 3'b101: misalign_s = bus.req_addr[0];
            3'b010:         misalign_s = (bus.req_addr[1:0] != 2'b00);
            default:        misalign_s = 1'b0;
        endcase
`else
        misalign_s = 1'b0;
`endif
    end

    // Errors are decided at acceptance so a bad request never touches memory.
    always_comb begin
        req_err_s = funct3_illegal(bus.req_store, bus.req_funct3)
                  | (bus.req_addr >= ADDR_LIMIT)
                  | misalign_s;
    end

    // Control FSM with all bus outputs registered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= IDLE;
            store_r      <= 1'b0;
            funct3_r     <= 3'd0;
            addr_lo_r    <= 2'd0;
            wdata_lo_r   <= 16'd0;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= 32'd0;
            mem_addr_r   <= 32'd0;
            mem_wdata_r  <= 32'd0;
            mem_we_r     <= 2'b00;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.req_valid) begin
                        store_r     <= bus.req_store;
                        funct3_r    <= bus.req_funct3;
                        addr_lo_r   <= bus.req_addr[1:0];
                        wdata_lo_r  <= bus.req_wdata[15:0];
                        req_ready_r <= 1'b0;
                        if (req_err_s) begin
                            state_r      <= RESP;
                            resp_valid_r <= 1'b1;
                            resp_err_r   <= 1'b1;
                            resp_rdata_r <= 32'd0;
                        end else if (bus.req_store && (bus.req_funct3 == 3'b010)) begin
                            state_r     <= WR;
                            mem_addr_r  <= {bus.req_addr[31:2], 2'b00};
                            mem_wdata_r <= bus.req_wdata;
                            mem_we_r    <= 2'b11;
                        end else begin
                            state_r    <= RD;
                            mem_addr_r <= {bus.req_addr[31:2], 2'b00};
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RD: begin
                    if (store_r) begin
                        state_r     <= WR;
                        mem_wdata_r <= store_merge(bus.mem_rdata, wdata_lo_r, funct3_r, addr_lo_r);
                        mem_we_r    <= 2'b11;
                    end else begin
                        state_r      <= RESP;
                        mem_addr_r   <= 32'd0;
                        resp_valid_r <= 1'b1;
                        resp_err_r   <= 1'b0;
                        resp_rdata_r <= load_extend(bus.mem_rdata, funct3_r, addr_lo_r);
                    end
                end
                WR: begin
                    state_r      <= RESP;
                    mem_we_r     <= 2'b00;
                    mem_addr_r   <= 32'd0;
                    mem_wdata_r  <= 32'd0;
                    resp_valid_r <= 1'b1;
                    resp_err_r   <= 1'b0;
                    resp_rdata_r <= 32'd0;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        state_r      <= IDLE;
                        resp_valid_r <= 1'b0;
                        resp_err_r   <= 1'b0;
                        resp_rdata_r <= 32'd0;
                        req_ready_r  <= 1'b1;
                    end else begin
                        state_r <= RESP;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    req_ready_r  <= 1'b1;
                    resp_valid_r <= 1'b0;
                    resp_err_r   <= 1'b0;
                    resp_rdata_r <= 32'd0;
                    mem_addr_r   <= 32'd0;
                    mem_wdata_r  <= 32'd0;
                    mem_we_r     <= 2'b00;
                end
            endcase
        end
    end

    assign bus.req_ready  = req_ready_r;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_err   = resp_err_r;
    assign bus.resp_rdata = resp_rdata_r;
    assign bus.mem_addr   = mem_addr_r;
    assign bus.mem_wdata  = mem_wdata_r;
    // Reset must cancel a write already on the bus in the same cycle.
    assign bus.mem_we     = mem_we_r & {2{rst}};
endmodule
